// File: rtl/johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// johnson_seq_ctrl
//
// Run controller for a WIDTH-stage Johnson (twisted-ring) counter.
//
// The block owns the ring register. It accepts start/stop/hold commands from
// the control logic and runs the ring in one of two modes:
//   - counted: a programmed number of steps
//   - continuous: runs until stopped
// On stop, the ring drains forward to the all-zero phase. The 2*WIDTH phases
// are decoded into one-hot strobes for the downstream timing logic.
//
// Ring sequence for WIDTH=4 (phase index k = position in this list):
//   0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      one-cycle command: begin a run (ignored while busy)
//   stop       one-cycle command: end the run at the next all-zero phase
//   hold       level: freeze ring and step counter while high
//   cont       sampled with start: 1 = continuous run, 0 = counted run
//   len        step count for a counted run, sampled with start
//   q_out      current ring state
//   phase_stb  one-hot phase decode of q_out; all-zero for an illegal value
//   busy       high while running or draining
//   done       one-cycle pulse when a run completes
//   err        one-cycle pulse when an illegal ring state is detected
//
// Build option
//   JSEQ_SELFCHECK_EN  When defined, q_out is checked against the legal
//                      patterns every cycle. An illegal value forces the ring
//                      to zero and the FSM to IDLE, and pulses err.
//                      When undefined, there is no check and err stays low.
// -----------------------------------------------------------------------------
module johnson_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               cont,
    input  logic [CNT_W-1:0]   len,
    output logic [WIDTH-1:0]   q_out,
    output logic [2*WIDTH-1:0] phase_stb,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int PHASES = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               mode;        // 1 = continuous, 0 = counted
    logic               mode_nxt;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W-1:0]   rem_nxt;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_nxt;
    logic [WIDTH-1:0]   q_adv;
    logic               done_nxt;
    logic               err_nxt;
    logic               finish;

    // Ring pattern for phase k.
    //   k <= WIDTH : the low k bits are set (the fill half of the sequence)
    //   k >  WIDTH : the high 2*WIDTH-k bits are set (the empty half)
    function automatic logic [WIDTH-1:0] phase_pattern(input int k);
        logic [WIDTH-1:0] p;
        for (int i = 0; i < WIDTH; i++) begin
            p[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
        end
        return p;
    endfunction

    // Twisted-ring shift: the inverted MSB feeds back into bit 0.
    assign q_adv = {q[WIDTH-2:0], ~q[WIDTH-1]};
    assign q_out = q;
    assign busy  = (state != IDLE);

    // Phase decode. An illegal ring value matches no pattern, so it yields
    // an all-zero strobe vector.
    always_comb begin
        phase_stb = '0;
        for (int k = 0; k < PHASES; k++) begin
            if (q == phase_pattern(k)) begin
                phase_stb[k] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            mode  <= 1'b0;
            rem   <= '0;
            q     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            mode  <= mode_nxt;
            rem   <= rem_nxt;
            q     <= q_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        rem_nxt   = rem;
        q_nxt     = q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        finish    = 1'b0;

        case (state)
            IDLE: begin
                // A stop alongside start cancels the start.
                // A counted start with len=0 completes immediately.
                if (start && !stop) begin
                    if (cont) begin
                        state_nxt = RUN;
                        mode_nxt  = 1'b1;
                    end else if (len != '0) begin
                        state_nxt = RUN;
                        mode_nxt  = 1'b0;
                        rem_nxt   = len;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end

            RUN, DRAIN: begin
                if (stop && (q == '0)) begin
                    // Already at phase 0: finish without advancing.
                    finish = 1'b1;
                end else if (hold) begin
                    // Frozen, but a stop is still registered. We are not at
                    // phase 0 here, so the run must drain.
                    if (stop) begin
                        state_nxt = DRAIN;
                    end
                end else begin
                    q_nxt = q_adv;
                    if (!mode) begin
                        rem_nxt = rem - 1'b1;
                    end
                    if ((state == DRAIN) || stop) begin
                        state_nxt = DRAIN;
                        if (q_adv == '0) begin
                            finish = 1'b1;
                        end
                    end
                    // A counted run ends on its last step, even mid-drain.
                    if (!mode && (rem == CNT_W'(1))) begin
                        finish = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (finish) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
        end

`ifdef JSEQ_SELFCHECK_EN
        // A legal ring value always decodes to exactly one strobe. Recovery
        // overrides any pending completion, so done is suppressed.
        if (phase_stb == '0) begin
            state_nxt = IDLE;
            mode_nxt  = 1'b0;
            rem_nxt   = '0;
            q_nxt     = '0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_johnson_seq_ctrl
//
// Directed testbench for johnson_seq_ctrl (WIDTH=4, CNT_W=8).
//
// Inputs are driven on the falling edge and outputs are observed on the
// following falling edge, i.e. one rising edge later. Expected ring values
// and strobes are hand-written constants.
// -----------------------------------------------------------------------------
module tb_johnson_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic             hold;
    logic             cont;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] q_out;
    logic [7:0]       phase_stb;
    logic             busy;
    logic             done;
    logic             err;

    int checks;
    int errors;
    int busy_cycles;

    johnson_seq_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .cont     (cont),
        .len      (len),
        .q_out    (q_out),
        .phase_stb(phase_stb),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Hand-written phase table for the 4-stage ring.
    function automatic logic [7:0] stb_of(input logic [3:0] v);
        case (v)
            4'b0000: return 8'h01;
            4'b0001: return 8'h02;
            4'b0011: return 8'h04;
            4'b0111: return 8'h08;
            4'b1111: return 8'h10;
            4'b1110: return 8'h20;
            4'b1100: return 8'h40;
            4'b1000: return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (busy) busy_cycles++;
    endtask

    // One clock edge, then check ring, strobe, busy and done.
    task automatic adv(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
        step();
        chk({tag, " q"},    32'(q_out),     32'(eq));
        chk({tag, " stb"},  32'(phase_stb), 32'(stb_of(eq)));
        chk({tag, " busy"}, 32'(busy),      32'(eb));
        chk({tag, " done"}, 32'(done),      32'(ed));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        busy_cycles = 0;
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        hold  = 1'b0;
        cont  = 1'b0;
        len   = '0;

        // Reset state.
        step();
        step();
        chk("rst q",    32'(q_out),     32'h0);
        chk("rst stb",  32'(phase_stb), 32'h01);
        chk("rst busy", 32'(busy),      32'h0);
        chk("rst done", 32'(done),      32'h0);
        chk("rst err",  32'(err),       32'h0);
        reset = 1'b1;
        adv("rel", 4'b0000, 1'b0, 1'b0);

        // Counted run, len=5.
        start = 1'b1; cont = 1'b0; len = 8'd5;
        adv("c5 go", 4'b0000, 1'b1, 1'b0);
        start = 1'b0;
        adv("c5 a1", 4'b0001, 1'b1, 1'b0);
        adv("c5 a2", 4'b0011, 1'b1, 1'b0);
        adv("c5 a3", 4'b0111, 1'b1, 1'b0);
        adv("c5 a4", 4'b1111, 1'b1, 1'b0);
        adv("c5 a5", 4'b1110, 1'b0, 1'b1);
        adv("c5 idle", 4'b1110, 1'b0, 1'b0);

        // Continuous run from phase 5, stopped at 0111.
        start = 1'b1; cont = 1'b1;
        adv("cr go", 4'b1110, 1'b1, 1'b0);
        start = 1'b0; cont = 1'b0;
        adv("cr a1", 4'b1100, 1'b1, 1'b0);
        adv("cr a2", 4'b1000, 1'b1, 1'b0);
        adv("cr a3", 4'b0000, 1'b1, 1'b0);
        adv("cr a4", 4'b0001, 1'b1, 1'b0);
        adv("cr a5", 4'b0011, 1'b1, 1'b0);
        adv("cr a6", 4'b0111, 1'b1, 1'b0);
        stop = 1'b1;
        adv("cr s1", 4'b1111, 1'b1, 1'b0);
        stop = 1'b0;
        adv("cr s2", 4'b1110, 1'b1, 1'b0);
        adv("cr s3", 4'b1100, 1'b1, 1'b0);
        adv("cr s4", 4'b1000, 1'b1, 1'b0);
        adv("cr s5", 4'b0000, 1'b0, 1'b1);
        adv("cr idle", 4'b0000, 1'b0, 1'b0);

        // Counted run, len=8, with hold for 3 cycles.
        busy_cycles = 0;
        start = 1'b1; cont = 1'b0; len = 8'd8;
        adv("h8 go", 4'b0000, 1'b1, 1'b0);
        start = 1'b0;
        adv("h8 a1", 4'b0001, 1'b1, 1'b0);
        adv("h8 a2", 4'b0011, 1'b1, 1'b0);
        adv("h8 a3", 4'b0111, 1'b1, 1'b0);
        hold = 1'b1;
        adv("h8 h1", 4'b0111, 1'b1, 1'b0);
        adv("h8 h2", 4'b0111, 1'b1, 1'b0);
        adv("h8 h3", 4'b0111, 1'b1, 1'b0);
        hold = 1'b0;
        adv("h8 a4", 4'b1111, 1'b1, 1'b0);
        adv("h8 a5", 4'b1110, 1'b1, 1'b0);
        adv("h8 a6", 4'b1100, 1'b1, 1'b0);
        adv("h8 a7", 4'b1000, 1'b1, 1'b0);
        adv("h8 a8", 4'b0000, 1'b0, 1'b1);
        chk("h8 busy cycles", 32'(busy_cycles), 32'd11);

        // Start with len=0: done next cycle, no advance.
        start = 1'b1; cont = 1'b0; len = 8'd0;
        adv("l0 go", 4'b0000, 1'b0, 1'b1);
        start = 1'b0;
        adv("l0 idle", 4'b0000, 1'b0, 1'b0);

        // Start and stop together while busy: stop wins, start ignored.
        start = 1'b1; cont = 1'b1;
        adv("ss go", 4'b0000, 1'b1, 1'b0);
        start = 1'b0; cont = 1'b0;
        adv("ss a1", 4'b0001, 1'b1, 1'b0);
        start = 1'b1; stop = 1'b1; len = 8'd3;
        adv("ss both", 4'b0011, 1'b1, 1'b0);
        start = 1'b0; stop = 1'b0;
        adv("ss d1", 4'b0111, 1'b1, 1'b0);
        adv("ss d2", 4'b1111, 1'b1, 1'b0);
        adv("ss d3", 4'b1110, 1'b1, 1'b0);
        adv("ss d4", 4'b1100, 1'b1, 1'b0);
        adv("ss d5", 4'b1000, 1'b1, 1'b0);
        adv("ss d6", 4'b0000, 1'b0, 1'b1);

        // Stop at phase 0: done after one cycle, no advance.
        start = 1'b1; cont = 1'b1;
        adv("z go", 4'b0000, 1'b1, 1'b0);
        start = 1'b0; cont = 1'b0; stop = 1'b1;
        adv("z stop", 4'b0000, 1'b0, 1'b1);
        stop = 1'b0;
        adv("z idle", 4'b0000, 1'b0, 1'b0);

        // Stop accepted during hold; drain resumes once hold drops.
        start = 1'b1; cont = 1'b1;
        adv("hs go", 4'b0000, 1'b1, 1'b0);
        start = 1'b0; cont = 1'b0;
        adv("hs a1", 4'b0001, 1'b1, 1'b0);
        hold = 1'b1; stop = 1'b1;
        adv("hs stop", 4'b0001, 1'b1, 1'b0);
        stop = 1'b0;
        adv("hs hold", 4'b0001, 1'b1, 1'b0);
        hold = 1'b0;
        adv("hs d1", 4'b0011, 1'b1, 1'b0);
        adv("hs d2", 4'b0111, 1'b1, 1'b0);
        adv("hs d3", 4'b1111, 1'b1, 1'b0);
        adv("hs d4", 4'b1110, 1'b1, 1'b0);
        adv("hs d5", 4'b1100, 1'b1, 1'b0);
        adv("hs d6", 4'b1000, 1'b1, 1'b0);
        adv("hs d7", 4'b0000, 1'b0, 1'b1);

        // Reset mid-run aborts with no done pulse.
        start = 1'b1; cont = 1'b0; len = 8'd5;
        adv("ra go", 4'b0000, 1'b1, 1'b0);
        start = 1'b0;
        adv("ra a1", 4'b0001, 1'b1, 1'b0);
        reset = 1'b0;
        adv("ra rst", 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        adv("ra rel", 4'b0000, 1'b0, 1'b0);
        adv("ra idle", 4'b0000, 1'b0, 1'b0);

        // Illegal ring value.
        force dut.q = 4'b0101;
        #1;
        chk("ill stb", 32'(phase_stb), 32'h0);
        step();
`ifdef JSEQ_SELFCHECK_EN
        chk("ill err",  32'(err),  32'h1);
        chk("ill done", 32'(done), 32'h0);
        chk("ill busy", 32'(busy), 32'h0);
`else
        chk("ill err",  32'(err),  32'h0);
        chk("ill done", 32'(done), 32'h0);
        step();
        chk("ill err2", 32'(err),  32'h0);
`endif
        release dut.q;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("post q",   32'(q_out), 32'h0);
        chk("post err", 32'(err),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
